// File: rtl/prime_stream_gen.sv
// prime_stream_gen: valid/ready stream containing exactly Target primes per run.
// Define PRIME_STREAM_FILLER_EN to interleave LFSR-chosen non-prime filler beats.
module prime_stream_gen (
  input  logic       Clk,
  input  logic       nRst,
  input  logic       Start,
  input  logic [7:0] Target,
  input  logic       Ready,
  output logic [3:0] B,
  output logic       Valid,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Sent
);
  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;
  localparam logic [3:0] PRIMES [6] = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
  state_t state;
  logic [7:0] tgt;
  logic [2:0] idx;
  logic [7:0] sent_inc;
  logic [2:0] idx_inc;
  logic fire;
  assign sent_inc = Sent + 8'd1;
  assign idx_inc = idx == 3'd5 ? 3'd0 : idx + 3'd1;
  assign fire = Valid && Ready;
`ifdef PRIME_STREAM_FILLER_EN
  localparam logic [3:0] FILLS [8] = '{4'd1, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12, 4'd14};
  logic [3:0] lfsr;
  logic [3:0] lfsr_nxt;
  logic filler;
  assign lfsr_nxt = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
`endif
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state <= S_IDLE;
      tgt <= 8'd0;
      idx <= 3'd0;
      B <= 4'd0;
      Valid <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      Sent <= 8'd0;
`ifdef PRIME_STREAM_FILLER_EN
      lfsr <= 4'b1001;
      filler <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          Sent <= 8'd0;
          idx <= 3'd0;
          Busy <= 1'b1;
`ifdef PRIME_STREAM_FILLER_EN
          lfsr <= 4'b1001;
          filler <= 1'b0;
`endif
          if (Target != 8'd0) begin
            tgt <= Target;
            B <= PRIMES[0];
            Valid <= 1'b1;
            state <= S_EMIT;
          end else begin
            Done <= 1'b1;
            state <= S_DONE;
          end
        end
        S_EMIT: if (fire) begin
`ifdef PRIME_STREAM_FILLER_EN
          lfsr <= lfsr_nxt;
          if (filler) begin
            filler <= 1'b0;
            B <= PRIMES[idx];
          end else
`endif
          begin
            Sent <= sent_inc;
            idx <= idx_inc;
            if (sent_inc == tgt) begin
              Valid <= 1'b0;
              Done <= 1'b1;
              state <= S_DONE;
            end else begin
`ifdef PRIME_STREAM_FILLER_EN
              // lfsr_nxt[0] picks filler vs prime; a filler is always followed by a prime
              filler <= lfsr_nxt[0];
              B <= lfsr_nxt[0] ? FILLS[lfsr_nxt[2:0]] : PRIMES[idx_inc];
`else
              B <= PRIMES[idx_inc];
`endif
            end
          end
        end
        S_DONE: begin
          Done <= 1'b0;
          Busy <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/prime_stream_gen.md
# prime_stream_gen

Stimulus source for the prime-counting datapath: on a start request it emits a stream of 4-bit unsigned values over a valid/ready handshake, containing exactly Target prime values. It is the transmit end of the 4-bit B bus consumed by the prime-counting receiver. A downstream counter attached to B therefore ends each run at a known, pre-programmed count. Optional LFSR-driven non-prime filler beats exercise the receiver's reject path.

## Interface
- No parameters; all widths fixed.
- Clk  in  1  rising-edge clock
- nRst  in  1  reset, asynchronous, active-low
- Start  in  1  run request; sampled only in IDLE
- Target  in  8  number of primes to emit in the run; sampled with Start
- Ready  in  1  downstream accepts current beat
- B  out  4  beat value, unsigned
- Valid  out  1  B holds a beat
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle pulse at run completion
- Sent  out  8  primes accepted downstream in the current or last run

## Operation
- Handshake:
  - A beat transfers on any rising edge where Valid && Ready.
  - While Valid && !Ready, B and Valid hold unchanged.
  - Valid never drops without a transfer, except on reset.
- Prime sequence:
  - 2, 3, 5, 7, 11, 13, then wrap to 2.
  - The index resets to 0 (value 2) on each accepted Start.
  - The index advances only on an accepted prime beat.
- State machine (IDLE, EMIT, DONE):
  - IDLE: Valid=0.
    - Start=1 with Target!=0: latch Target, clear Sent, go to EMIT.
    - Start=1 with Target==0: clear Sent, go to DONE; no beats emitted.
  - EMIT: Valid=1.
    - On an accepted prime beat, Sent increments.
    - If the incremented Sent equals the latched Target, go to DONE.
  - DONE: Valid=0, Done=1 for exactly one cycle, then go to IDLE.
- Start and Target are ignored in EMIT and DONE. Target changes after latching have no effect.
- Sent holds its value in IDLE until the next accepted Start. No overflow is possible because Target ≤ 255.
- Reset values: state IDLE, B=0, Valid=0, Busy=0, Done=0, Sent=0, prime index 0, LFSR 4'b1001.
- Reset asserted mid-run aborts immediately: all outputs go to reset values and no Done pulse is produced.

## Timing
- Start accepted at edge t: Busy=1 and Valid=1 with B=2 from cycle t+1.
- Throughput: one beat per cycle while Ready=1.
- Target==0: Done=1 in cycle t+1, Busy=0 from cycle t+2.
- Final prime accepted at edge u:
  - Sent reaches Target in cycle u+1.
  - Valid=0 and Done=1 in cycle u+1.
  - Busy=0 from cycle u+2.
- A new Start is accepted no earlier than cycle u+2 (back-to-back runs have one idle cycle).

## Configuration
- Macro: PRIME_STREAM_FILLER_EN.
- Defined:
  - A 4-bit Fibonacci LFSR updates next = {lfsr[2:0], lfsr[3]^lfsr[2]} on every accepted beat, prime or filler.
  - The LFSR is reseeded to 4'b1001 on each accepted Start.
  - After an accepted prime beat that does not finish the run: if the updated lfsr[0]==1, the next beat is a filler value, otherwise it is the next prime.
  - Filler value = {1,4,6,8,9,10,12,14}[updated lfsr[2:0]].
  - The beat following a filler is always a prime.
  - Fillers do not change Sent or the prime index.
  - The first beat of every run is 2.
- Not defined: no LFSR and no filler logic; every beat is a prime.

## Test plan
- No filler, Target=3, Ready=1 → B=2,3,5 on three consecutive cycles; Done pulse the next cycle; Sent=3.
- No filler, Target=7 → B=2,3,5,7,11,13,2 (index wrap); Sent=7; exactly one Done pulse.
- Ready=0 for 3 cycles after Start (Target=1) → Valid=1 with B=2 held stable all 3 cycles; transfer when Ready rises; Done on the following cycle.
- PRIME_STREAM_FILLER_EN, Target=2, Ready=1 → B=2, 8, 3; Sent=2; Done after the third beat.
- Target=0 → Done pulse at t+1, Valid never asserted, Sent=0. Separately, Start held during EMIT → ignored, run length unchanged.
- Reset pulse mid-run (Target=200, after 10 beats) → Valid, Busy, Done and Sent all go to 0 immediately; no Done pulse; the next Start restarts at B=2.
